// File: rtl/conv_share_arbiter.sv
// conv_share_arbiter
// Shares one ready/valid convolution unit (one transaction in flight) among
// NREQ requesters. Grants are round-robin; each granted request runs
// send -> compute -> return to completion before the next grant is issued.
// Payloads and results pass through bit-exact.
module conv_share_arbiter #(
    parameter  int NREQ = 4,
    parameter  int E    = 16,
    parameter  int W    = 8,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NREQ-1:0]                  req_valid,
    output logic [NREQ-1:0]                  req_ready,
    input  logic [NREQ-1:0][E-1:0][W-1:0]    req_data,
    output logic [NREQ-1:0]                  resp_valid,
    input  logic [NREQ-1:0]                  resp_ready,
    output logic [E*W-1:0]                   resp_data,
    output logic                             conv_valid,
    input  logic                             conv_ready,
    output logic [E*W-1:0]                   conv_data,
    input  logic                             conv_rvalid,
    output logic                             conv_rready,
    input  logic [E*W-1:0]                   conv_rdata,
    output logic                             busy,
    output logic [IDW-1:0]                   grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [IDW-1:0]  ptr_r;
    logic [IDW-1:0]  grant_id_r;
    logic [IDW-1:0]  sel_id_s;
    logic [IDW-1:0]  idx_s;
    logic            sel_found_s;
    logic            accept_s;
    logic            done_s;
    logic [E*W-1:0]  payload_r;
    logic [E*W-1:0]  result_r;

    // Round-robin search: the valid requester at the smallest offset from ptr_r wins.
    always_comb begin
        sel_found_s = 1'b0;
        sel_id_s    = '0;
        idx_s       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx_s = IDW'((int'(ptr_r) + i) % NREQ);
            if (req_valid[idx_s]) begin
                sel_found_s = 1'b1;
                sel_id_s    = idx_s;
            end else begin
                sel_found_s = sel_found_s;
                sel_id_s    = sel_id_s;
            end
        end
    end

    assign accept_s = (state_r == ST_IDLE) && sel_found_s;
    assign done_s   = (state_r == ST_RESP) && resp_ready[grant_id_r];

    // State register; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: each phase advances on its own handshake only.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: state_s = sel_found_s ? ST_SEND : ST_IDLE;
            ST_SEND: state_s = conv_ready ? ST_WAIT : ST_SEND;
            ST_WAIT: state_s = conv_rvalid ? ST_RESP : ST_WAIT;
            ST_RESP: state_s = resp_ready[grant_id_r] ? ST_IDLE : ST_RESP;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode; req_ready is the only path combinational in req_valid.
    always_comb begin
        req_ready   = '0;
        resp_valid  = '0;
        conv_valid  = 1'b0;
        conv_rready = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sel_found_s && !reset) begin
                    req_ready[sel_id_s] = 1'b1;
                end else begin
                    req_ready = '0;
                end
            end
            ST_SEND: conv_valid  = 1'b1;
            ST_WAIT: conv_rready = 1'b1;
            ST_RESP: resp_valid[grant_id_r] = 1'b1;
            default: begin
                req_ready   = '0;
                resp_valid  = '0;
                conv_valid  = 1'b0;
                conv_rready = 1'b0;
            end
        endcase
    end

    // Capture the granted payload and its id at the request handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            payload_r  <= '0;
            grant_id_r <= '0;
        end else if (accept_s) begin
            payload_r  <= req_data[sel_id_s];
            grant_id_r <= sel_id_s;
        end
    end

    // Capture the conv result when it is handed back.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r <= '0;
        end else if ((state_r == ST_WAIT) && conv_rvalid) begin
            result_r <= conv_rdata;
        end
    end

    // Advance the round-robin pointer past the id just served.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (done_s) begin
            ptr_r <= IDW'((int'(grant_id_r) + 1) % NREQ);
        end
    end

    assign conv_data = payload_r;
    assign resp_data = result_r;
    assign busy      = (state_r != ST_IDLE);
    assign grant_id  = grant_id_r;

`ifndef SYNTHESIS
    // Flag a result offered by the conv unit while no result is expected.
    always @(posedge clk) begin
        if (!reset && conv_rvalid && (state_r != ST_WAIT)) begin
            $error("conv_share_arbiter: conv_rvalid outside WAIT is ignored");
        end
    end
`endif

endmodule

// File: tb/tb_conv_share_arbiter.sv
// Bench for conv_share_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the arbiter and a simple conv
// unit model that adds 2 to every element.
module tb_conv_share_arbiter;

    localparam int NREQ = 4;
    localparam int E    = 16;
    localparam int W    = 8;
    localparam int DW   = E * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                          reset;
    logic [NREQ-1:0]               req_valid, req_ready, resp_valid, resp_ready;
    logic [NREQ-1:0][E-1:0][W-1:0] req_data;
    logic [DW-1:0]                 resp_data, conv_data, conv_rdata;
    logic                          conv_valid, conv_ready, conv_rvalid, conv_rready, busy;
    logic [1:0]                    grant_id;

    conv_share_arbiter #(.NREQ(NREQ), .E(E), .W(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .conv_valid(conv_valid), .conv_ready(conv_ready), .conv_data(conv_data),
        .conv_rvalid(conv_rvalid), .conv_rready(conv_rready), .conv_rdata(conv_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    // Single-requester build with an always-ready conv unit answering immediately.
    logic [0:0]                    r1_req_valid, r1_req_ready, r1_resp_valid, r1_resp_ready;
    logic [0:0][E-1:0][W-1:0]      r1_req_data;
    logic [DW-1:0]                 r1_resp_data, r1_conv_data, r1_conv_rdata;
    logic                          r1_conv_valid, r1_conv_ready, r1_conv_rvalid, r1_conv_rready, r1_busy;
    logic [0:0]                    r1_grant_id;

    conv_share_arbiter #(.NREQ(1), .E(E), .W(W)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(r1_req_valid), .req_ready(r1_req_ready), .req_data(r1_req_data),
        .resp_valid(r1_resp_valid), .resp_ready(r1_resp_ready), .resp_data(r1_resp_data),
        .conv_valid(r1_conv_valid), .conv_ready(r1_conv_ready), .conv_data(r1_conv_data),
        .conv_rvalid(r1_conv_rvalid), .conv_rready(r1_conv_rready), .conv_rdata(r1_conv_rdata),
        .busy(r1_busy), .grant_id(r1_grant_id)
    );

    // Conv unit behaviour: every element plus 2, wrapping at W bits.
    function automatic logic [DW-1:0] conv_fn(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < E; k++) r[k*W +: W] = d[k*W +: W] + W'(2);
        return r;
    endfunction

    assign r1_conv_rvalid = r1_conv_rready;
    assign r1_conv_rdata  = conv_fn(r1_conv_data);

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Transaction-level model of the arbiter.
    bit            m_out = 1'b0, m_sent = 1'b0, m_got = 1'b0;
    int            m_gid = 0, m_ptr = 0;
    logic [DW-1:0] m_payload = '0;
    int            grants[$];
    int            done_cnt = 0, cyc = 0, acc_cyc = 0, resp_cyc = 0;
    bit            resp_seen = 1'b0;
    logic [DW-1:0] resp_snap = '0;
    logic [NREQ-1:0] resp_vsnap = '0;

    // Conv unit model.
    bit            cm_busy = 1'b0;
    int            cm_delay = 0, cm_max_delay = 0;
    logic [DW-1:0] cm_data = '0;

    // Stimulus policies.
    logic [NREQ-1:0] req_enable = '0, resp_low = '0;
    int              req_pct = 0, conv_rdy_pct = 100, rr_pct = 100;
    bit              fixed_data = 1'b0;
    bit              req_drop[NREQ];

    function automatic int model_phase();
        if (!m_out) return 0;
        else if (!m_sent) return 1;
        else if (!m_got) return 2;
        else return 3;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (req_drop[i]) begin
                req_valid[i] = 1'b0;
                req_drop[i]  = 1'b0;
            end
            if (!req_valid[i] && req_enable[i] && int'($urandom_range(0, 99)) < req_pct) begin
                req_valid[i] = 1'b1;
                for (int k = 0; k < E; k++) req_data[i][k] = fixed_data ? W'(k) : W'($urandom);
            end
            resp_ready[i] = (int'($urandom_range(0, 99)) < rr_pct) && !resp_low[i];
        end
        conv_ready = int'($urandom_range(0, 99)) < conv_rdy_pct;
        if (cm_busy && cm_delay == 0) begin
            conv_rvalid = 1'b1;
            conv_rdata  = cm_data;
        end else begin
            conv_rvalid = 1'b0;
            conv_rdata  = {$urandom, $urandom, $urandom, $urandom};
            if (cm_busy) cm_delay--;
        end
    endtask

    // One clock: check outputs at the falling edge, update models, drive after the rising edge.
    task automatic step();
        logic [NREQ-1:0] exp_rr, exp_rv;
        bit found;
        int g, c;
        @(negedge clk);
        cyc++;
        found = 1'b0;
        g     = 0;
        for (int i = 0; i < NREQ; i++) begin
            c = (m_ptr + i) % NREQ;
            if (!found && req_valid[c]) begin
                found = 1'b1;
                g     = c;
            end
        end
        exp_rr = (!reset && !m_out && found) ? (NREQ'(1) << g) : '0;
        exp_rv = (m_out && m_got) ? (NREQ'(1) << m_gid) : '0;
        check("req_ready",   DW'(req_ready),   DW'(exp_rr));
        check("busy",        DW'(busy),        DW'(m_out));
        check("grant_id",    DW'(grant_id),    DW'(m_gid));
        check("conv_valid",  DW'(conv_valid),  DW'(m_out && !m_sent));
        check("conv_rready", DW'(conv_rready), DW'(m_out && m_sent && !m_got));
        check("resp_valid",  DW'(resp_valid),  DW'(exp_rv));
        if (m_out && !m_sent) check("conv_data", conv_data, m_payload);
        if (m_out && m_got) begin
            check("resp_data", resp_data, conv_fn(m_payload));
            if (!resp_seen) begin
                resp_seen  = 1'b1;
                resp_cyc   = cyc;
                resp_snap  = resp_data;
                resp_vsnap = resp_valid;
            end
        end
        if (reset) begin
            m_out = 1'b0; m_sent = 1'b0; m_got = 1'b0;
            m_gid = 0; m_ptr = 0; m_payload = '0;
            cm_busy = 1'b0;
        end else if (!m_out) begin
            if (found) begin
                m_out = 1'b1; m_sent = 1'b0; m_got = 1'b0;
                m_gid = g; m_payload = req_data[2'(g)];
                grants.push_back(g);
                acc_cyc = cyc; resp_seen = 1'b0;
                req_drop[g] = 1'b1;
            end
        end else if (!m_sent) begin
            if (conv_ready) begin
                m_sent   = 1'b1;
                cm_busy  = 1'b1;
                cm_data  = conv_fn(conv_data);
                cm_delay = $urandom_range(0, cm_max_delay);
            end
        end else if (!m_got) begin
            if (conv_rvalid) begin
                m_got   = 1'b1;
                cm_busy = 1'b0;
            end
        end else if (resp_ready[2'(m_gid)]) begin
            m_out = 1'b0;
            m_ptr = (m_gid + 1) % NREQ;
            done_cnt++;
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = '0;
        req_enable = '0;
        resp_low   = '0;
        for (int i = 0; i < NREQ; i++) req_drop[i] = 1'b0;
        step();
        step();
        reset = 1'b0;
        grants.delete();
        done_cnt = 0;
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (done_cnt < n && k < budget) begin
            step();
            k++;
        end
        check(tag, DW'(done_cnt), DW'(n));
    endtask

    task automatic wait_phase(input int ph, input int budget, input string tag);
        int k;
        k = 0;
        while (model_phase() != ph && k < budget) begin
            step();
            k++;
        end
        check(tag, DW'(model_phase()), DW'(ph));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] snap, ramp2, r1_lat;
        int n0, r1_last, n_acc;
        bit acc;

        reset = 1'b1;
        req_valid = '0; req_data = '0; resp_ready = '0;
        conv_ready = 1'b0; conv_rvalid = 1'b0; conv_rdata = '0;
        r1_req_valid = '0; r1_req_data = '0; r1_resp_ready = '0; r1_conv_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) req_drop[i] = 1'b0;

        // Reset state.
        do_reset();
        check("rst_conv_data", conv_data, '0);
        check("rst_resp_data", resp_data, '0);
        check("rst_busy",      DW'(busy), '0);
        check("rst_grant_id",  DW'(grant_id), '0);

        // Single request from requester 2, ramp payload, conv answers after one cycle.
        req_enable = 4'b0100; req_pct = 100; fixed_data = 1'b1;
        conv_rdy_pct = 100; cm_max_delay = 0; rr_pct = 100;
        wait_done(1, 50, "t1_done");
        ramp2 = '0;
        for (int k = 0; k < E; k++) ramp2[k*W +: W] = W'(k + 2);
        check("t1_grant",      DW'(grants[0]), DW'(2));
        check("t1_latency",    DW'(resp_cyc - acc_cyc), DW'(3));
        check("t1_resp_data",  resp_snap, ramp2);
        check("t1_resp_valid", DW'(resp_vsnap), DW'(4'b0100));
        fixed_data = 1'b0;

        // All requesters continuously valid: grant order 0,1,2,3,0.
        do_reset();
        req_enable = 4'b1111; req_pct = 100;
        wait_done(5, 100, "t2_done");
        for (int i = 0; i < 5; i++) check("t2_order", DW'(grants[i]), DW'(i % NREQ));

        // conv_ready low for 5 cycles in SEND: payload held, no new grants.
        do_reset();
        req_enable = 4'b0001; conv_rdy_pct = 0;
        wait_phase(1, 20, "t3_send");
        req_enable = 4'b1111;
        snap = conv_data;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_conv_valid", DW'(conv_valid), DW'(1));
            check("t3_conv_data",  conv_data, snap);
        end
        conv_rdy_pct = 100;
        wait_done(1, 30, "t3_done");

        // resp_ready[1] withheld 4 cycles while requester 0 waits; next grant is 0.
        do_reset();
        req_enable = 4'b0010; resp_low = 4'b0010;
        wait_phase(3, 30, "t4_resp");
        req_enable = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_resp_hold", DW'(resp_valid), DW'(4'b0010));
        end
        resp_low = '0;
        wait_done(2, 40, "t4_done");
        check("t4_first",  DW'(grants[0]), DW'(1));
        check("t4_second", DW'(grants[1]), DW'(0));

        // Reset while in WAIT: transaction dropped, next grant starts from 0.
        do_reset();
        req_enable = 4'b0010; cm_max_delay = 3;
        wait_done(1, 40, "t5_first");
        wait_phase(2, 40, "t5_wait");
        cm_delay   = 20;
        req_enable = 4'b1111;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_busy",        DW'(busy), '0);
        check("t5_conv_valid",  DW'(conv_valid), '0);
        check("t5_conv_rready", DW'(conv_rready), '0);
        check("t5_resp_valid",  DW'(resp_valid), '0);
        check("t5_grant_id",    DW'(grant_id), '0);
        check("t5_conv_data",   conv_data, '0);
        check("t5_resp_data",   resp_data, '0);
        n0 = grants.size();
        wait_done(1, 40, "t5_next");
        check("t5_next_grant", DW'(grants[n0]), DW'(0));

        // Randomized traffic with occasional resets.
        do_reset();
        req_enable = 4'b1111; req_pct = 30; conv_rdy_pct = 60; cm_max_delay = 3; rr_pct = 50;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end else begin
                step();
            end
        end

        // Single-requester build: back-to-back requests every 4 cycles, id always 0.
        do_reset();
        conv_rdy_pct = 100; rr_pct = 100;
        r1_req_valid  = 1'b1;
        r1_resp_ready = 1'b1;
        for (int k = 0; k < E; k++) r1_req_data[0][k] = W'($urandom);
        r1_last = 0; n_acc = 0; r1_lat = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("t6_grant_id", DW'(r1_grant_id), '0);
            if (r1_resp_valid[0]) check("t6_resp_data", r1_resp_data, conv_fn(r1_lat));
            acc = r1_req_valid[0] && r1_req_ready[0];
            if (acc) begin
                if (n_acc > 0) check("t6_interval", DW'(c - r1_last), DW'(4));
                r1_last = c;
                n_acc++;
                r1_lat = r1_req_data;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                for (int k = 0; k < E; k++) r1_req_data[0][k] = W'($urandom);
            end
        end
        check("t6_accepts", DW'(n_acc), DW'(10));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
